// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM encoding, iteration count.
package md_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned ITER_COUNT = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } md_state_e;

    // Ops that occupy the iterative datapath (mult/div family).
    function automatic logic is_iter_op(logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // Magnitude of v when treated as signed, otherwise v unchanged.
    function automatic logic [XLEN-1:0] mag(logic [XLEN-1:0] v, logic is_signed);
        return (is_signed && v[XLEN-1]) ? XLEN'(32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/md_divider.sv
// Radix-2 restoring divider on unsigned magnitudes; one quotient bit per step.
module md_divider
    import md_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic            fits;

    // Bring down the next dividend bit and try subtracting the divisor.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dsr_q};
        fits    = (shifted >= {1'b0, dsr_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
        end else if (step) begin
            quo_q <= {quo_q[XLEN-2:0], fits};
            rem_q <= fits ? XLEN'(trial) : XLEN'(shifted);
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/md_unit.sv
// MIPS-style HI/LO multiply/divide unit: 32 iterations plus a finish cycle per mult/div.
module md_unit
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    md_op_e            op_q;
    logic              neg_q;
    logic              rneg_q;
    logic              dz_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] prod_q;

    logic              req;
    logic              accept;
    logic              step;
    logic              fin_write;
    logic              mt_hi;
    logic              mt_lo;
    logic              busy_d;
    logic              done_d;

    logic              op_signed;
    logic              op_is_div;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN:0]     mult_sum;
    logic [2*XLEN-1:0] mult_res;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    assign req = start && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req && is_iter_op(op)) state_d = ST_RUN;
            ST_RUN: begin
                if (flush)                                 state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        step      = 1'b0;
        fin_write = 1'b0;
        mt_hi     = 1'b0;
        mt_lo     = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d == ST_RUN) || (state_d == ST_FIN);
        case (state_q)
            ST_IDLE: begin
                accept = req && is_iter_op(op);
                mt_hi  = req && (op == OP_MTHI);
                mt_lo  = req && (op == OP_MTLO);
            end
            ST_RUN:  step = !flush;
            ST_FIN: begin
                done_d    = !flush;
                fin_write = !flush && !(op_is_div && dz_q);
            end
            default: ;
        endcase
    end

    // Operand conditioning and sign-corrected results.
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
        mag_a     = mag(a, op_signed);
        mag_b     = mag(b, op_signed);
        mult_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mult_res  = neg_q ? (2*XLEN)'(64'd0 - prod_q) : prod_q;
        quot_fix  = neg_q ? XLEN'(32'd0 - quot) : quot;
        rem_fix   = rneg_q ? XLEN'(32'd0 - rem) : rem;
    end

    md_divider u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (step && op_is_div),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quot),
        .remainder (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (accept) begin
                cnt_q   <= '0;
                op_q    <= md_op_e'(op);
                neg_q   <= op_signed && (a[31] ^ b[31]);
                rneg_q  <= op_signed && a[31];
                dz_q    <= (b == 32'd0);
                mcand_q <= mag_b;
                prod_q  <= {32'd0, mag_a};
            end else if (step) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (!op_is_div) prod_q <= {mult_sum, prod_q[XLEN-1:1]};
            end else if (state_d == ST_IDLE) begin
                cnt_q <= '0;
            end
            if (mt_hi) hi <= a;
            if (mt_lo) lo <= a;
            if (fin_write) begin
                if (op_is_div) begin
                    hi <= rem_fix;
                    lo <= quot_fix;
                end else begin
                    hi <= mult_res[2*XLEN-1:XLEN];
                    lo <= mult_res[XLEN-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table, random ops with a reference model, flush/reset sequences.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op_in = 3'd0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op_in),
        .a     (a_in),
        .b     (b_in),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        keep;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference results from native arithmetic; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        logic [63:0] xa, xb;
        int sa, sb;
        case (op)
            3'd0: begin
                xa = {{32{a[31]}}, a};
                xb = {{32{b[31]}}, b};
                return xa * xb;
            end
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {h, l};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = a;
                sb = b;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'd0) return {h, l};
                return {a % b, a / b};
            end
            default: return {h, l};
        endcase
    endfunction

    // Issue one mult/div, measure busy length, and score HI/LO at the done pulse.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input bit inject);
        exp_t e;
        exp_t got;
        int busy_n = 0;
        int early_done = 0;
        int guard = 0;
        e.hi = ehi;
        e.lo = elo;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        op_in = op;
        a_in  = a;
        b_in  = b;
        @(posedge clk); #1;
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        while (busy && guard < 100) begin
            busy_n++;
            if (done) early_done++;
            if (inject && busy_n == 5) begin
                start = 1'b1;
                op_in = 3'd1;
                a_in  = $urandom;
                b_in  = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        check32("busy_cycles", 32'(busy_n), 32'd33);
        check32("done_during_busy", 32'(early_done), 32'd0);
        check32("done_pulse", {31'd0, done}, 32'd1);
        if (done && sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check32("hi", hi, got.hi);
            check32("lo", lo, got.lo);
        end else begin
            checks++;
            failures++;
            $display("FAIL result_missing done=%0d queued=%0d", done, sb_q.size());
            void'(sb_q.pop_front());
        end
        @(posedge clk); #1;
        check32("done_one_cycle", {31'd0, done}, 32'd0);
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3]  = '{3'd3, 32'h0000_0007, 32'h0000_0000, 1'b1, 32'h0, 32'h0};
        tbl[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000};
        tbl[5]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000};
        tbl[6]  = '{3'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000};
        tbl[7]  = '{3'd3, 32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0000_0002, 32'h0000_000E};
        tbl[8]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[9]  = '{3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003};
        tbl[10] = '{3'd2, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0, 32'h0};
        tbl[11] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // Table vectors; the first is accepted on the first edge after reset release.
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].keep) run_op(tbl[i].op, tbl[i].a, tbl[i].b, cur_hi, cur_lo, 1'b0);
            else             run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo, i == 0);
        end

        // Random mult/div against the reference model.
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            logic [63:0] r;
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 300)) : $urandom);
            r   = model(rop, ra, rb, cur_hi, cur_lo);
            run_op(rop, ra, rb, r[63:32], r[31:0], i == 2);
        end

        // MTHI / MTLO write immediately without going busy.
        @(negedge clk);
        start = 1'b1; op_in = 3'd4; a_in = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        check32("mthi_hi", hi, 32'h1234_5678);
        check32("mthi_busy", {31'd0, busy}, 32'd0);
        check32("mthi_done", {31'd0, done}, 32'd0);
        cur_hi = 32'h1234_5678;
        @(negedge clk);
        start = 1'b1; op_in = 3'd5; a_in = 32'hCAFE_0001;
        @(posedge clk); #1;
        start = 1'b0;
        check32("mtlo_lo", lo, 32'hCAFE_0001);
        check32("mtlo_hi_kept", hi, cur_hi);
        check32("mtlo_busy", {31'd0, busy}, 32'd0);
        cur_lo = 32'hCAFE_0001;

        // Flush together with start in IDLE drops the request.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op_in = 3'd4; a_in = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check32("flush_mthi_hi", hi, cur_hi);
        op_in = 3'd2; b_in = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check32("flush_div_busy", {31'd0, busy}, 32'd0);

        // MULT aborted by flush on RUN cycle 10, with an ignored start on RUN cycle 5.
        @(negedge clk);
        start = 1'b1; op_in = 3'd0; a_in = 32'd3; b_in = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            start = (k == 5);
            op_in = 3'd1;
            flush = (k == 10);
            @(posedge clk); #1;
        end
        start = 1'b0; flush = 1'b0;
        check32("flush_busy", {31'd0, busy}, 32'd0);
        check32("flush_hi", hi, cur_hi);
        check32("flush_lo", lo, cur_lo);
        begin
            int dn = 0;
            int bn = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (done) dn++;
                if (busy) bn++;
            end
            check32("flush_no_done", 32'(dn), 32'd0);
            check32("flush_no_restart", 32'(bn), 32'd0);
        end

        // Asynchronous reset in the middle of a MULT.
        @(negedge clk);
        start = 1'b1; op_in = 3'd0; a_in = 32'd7; b_in = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        check32("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check32("async_rst_hi", hi, 32'd0);
        check32("async_rst_lo", lo, 32'd0);
        check32("async_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int dn = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (done) dn++;
            end
            check32("rst_no_done", 32'(dn), 32'd0);
        end
        cur_hi = '0;
        cur_lo = '0;
        run_op(3'd3, 32'd100, 32'd0, cur_hi, cur_lo, 1'b0);

        check32("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request strobe from EX stage, sampled on rising clk.
REQ-005 op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6/7 SHALL be ignored as no-op.
REQ-006 a  input  32  rs operand (register-file port qa, after forwarding).
REQ-007 b  input  32  rt operand (register-file port qb, after forwarding).
REQ-008 flush  input  1  abort the in-flight operation (branch/exception squash).
REQ-009 busy  output  1  operation in flight; pipeline stalls MFHI/MFLO/new MD ops while high.
REQ-010 done  output  1  one-cycle pulse on the cycle HI/LO receive a mult/div result.
REQ-011 hi  output  32  HI register, driven directly from a flop.
REQ-012 lo  output  32  LO register, driven directly from a flop.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FIN; reset state IDLE.
REQ-014 IDLE & start & !flush & op in {0..3}: latch operands and op, clear 6-bit counter, go RUN; busy SHALL be 1 from the next cycle.
REQ-015 RUN: one radix-2 iteration per cycle (shift-add multiply, restoring divide on magnitudes), 32 cycles, then FIN.
REQ-016 FIN: apply sign correction, write HI/LO, pulse done, return to IDLE; busy SHALL be high for exactly 33 cycles and HI/LO SHALL update at edge N+33 after the accepting edge N.
REQ-017 MULT/MULTU: {hi,lo} SHALL equal the signed/unsigned 64-bit product of a and b.
REQ-018 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes the sign of the dividend.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-020 Divide by zero SHALL run the full 33 cycles, pulse done, and leave HI/LO unchanged.
REQ-021 MTHI/MTLO with start in IDLE SHALL write a into hi/lo at that edge, busy stays 0, done stays 0.
REQ-022 start while busy SHALL be ignored (no restart, no operand latch).
REQ-023 flush in RUN or FIN SHALL return to IDLE at the next edge with HI/LO unchanged and no done pulse; flush with start in IDLE SHALL win (request dropped).
REQ-024 Operands SHALL be sampled only at acceptance; later changes on a/b SHALL not affect the result.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL discard the operation; no done pulse after release.
REQ-027 First start SHALL be honoured on the first rising edge with rst_n high.

Structure
REQ-028 Shared package md_pkg SHALL hold op encodings, FSM state encoding, and ITER_COUNT=32.
REQ-029 The iterative divider datapath SHALL be one sub-module md_divider (magnitude inputs, quotient/remainder outputs, step enable); multiply datapath stays inline.
REQ-030 No combinational path SHALL exist from start/op/a/b to busy, done, hi, or lo.

Verification
REQ-031 MULT a=0xFFFFFFFE, b=0x00000003 -> busy high 33 cycles, done one pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 DIV a=0xFFFFFFF9, b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> hi/lo unchanged, done pulses.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-035 MULT started, flush on RUN cycle 10, start asserted on RUN cycle 5 -> busy low after flush edge, hi/lo hold prior values, no done pulse.
REQ-036 MTHI a=0x12345678 -> hi=0x12345678 next edge, busy stays 0; rst_n low on RUN cycle 20 -> hi=lo=0, busy=0 without a clock edge.
